// File: rtl/freq_detect.sv
// Peak-frequency detector: scans channel-1 FFT bins, tracks the largest re^2+im^2
// and holds the winning bin for the weight stage until it signals completion.
module freq_detect #(
   parameter logic [9:0]  MINBIN = 10'd1,
   parameter logic [9:0]  MAXBIN = 10'd511,
   parameter logic [27:0] THRESH = 28'd4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fftdone,
   input  logic [27:0] ram1q,
   input  logic        wbdone,
   output logic [9:0]  rdaddr1,
   output logic [9:0]  maxbin,
   output logic [27:0] maxpwr,
   output logic        detectdone,
   output logic        nosig,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, HOLD} state_t;

   state_t             state;
   logic [1:0]         drain_cnt;
   logic               vld_p0;
   logic               vld_p1;
   logic [9:0]         bin_p1;
   logic [27:0]        pwr_p1;

   // Squares of 14-bit signed parts are at most 2^26 each, so the sum fits 28 bits.
   function automatic logic [27:0] power(input logic [27:0] q);
      logic signed [27:0] re;
      logic signed [27:0] im;
      re = {{14{q[27]}}, q[27:14]};
      im = {{14{q[13]}}, q[13:0]};
      return $unsigned(re * re) + $unsigned(im * im);
   endfunction

   // P1: bin power and its tag, sampled one cycle after the address was registered
   always_ff @(posedge clk) begin
      pwr_p1 <= power(ram1q);
      bin_p1 <= rdaddr1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) vld_p1 <= 1'b0;
      else        vld_p1 <= vld_p0;
   end

   // P2: strict greater-than compare keeps the lowest bin on ties
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         drain_cnt  <= 2'd0;
         vld_p0     <= 1'b0;
         rdaddr1    <= 10'd0;
         maxbin     <= 10'd0;
         maxpwr     <= 28'd0;
         detectdone <= 1'b0;
         nosig      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         nosig  <= 1'b0;
         vld_p0 <= 1'b0;
         if (vld_p1 && (pwr_p1 > maxpwr)) begin
            maxpwr <= pwr_p1;
            maxbin <= bin_p1;
         end
         case (state)
            IDLE: begin
               if (fftdone) begin
                  state   <= SCAN;
                  busy    <= 1'b1;
                  rdaddr1 <= MINBIN;
                  maxpwr  <= 28'd0;
                  maxbin  <= 10'd0;
                  vld_p0  <= 1'b1;
               end
            end
            SCAN: begin
               if (rdaddr1 == MAXBIN) begin
                  state     <= DRAIN;
                  drain_cnt <= 2'd0;
               end else begin
                  rdaddr1 <= rdaddr1 + 10'd1;
                  vld_p0  <= 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt == 2'd2) begin
                  busy <= 1'b0;
                  if (maxpwr >= THRESH) begin
                     state      <= HOLD;
                     detectdone <= 1'b1;
                     rdaddr1    <= maxbin;
                  end else begin
                     state   <= IDLE;
                     nosig   <= 1'b1;
                     rdaddr1 <= 10'd0;
                  end
               end else begin
                  drain_cnt <= drain_cnt + 2'd1;
               end
            end
            HOLD: begin
               if (wbdone) begin
                  state      <= IDLE;
                  detectdone <= 1'b0;
                  rdaddr1    <= 10'd0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_detect.sv
// Bench for freq_detect: RAM model, per-frame prefix-maximum reference and
// cycle-by-cycle output comparison, plus directed scenarios with literal results.
module tb_freq_detect;

   localparam int          MINB = 1;
   localparam int          MAXB = 511;
   localparam int          NB   = MAXB - MINB + 1;
   localparam logic [27:0] TH   = 28'd4096;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fftdone = 1'b0;
   logic        wbdone = 1'b0;
   logic [27:0] ram1q;
   logic [9:0]  rdaddr1;
   logic [9:0]  maxbin;
   logic [27:0] maxpwr;
   logic        detectdone;
   logic        nosig;
   logic        busy;

   logic [27:0] mem [0:1023];

   freq_detect #(.MINBIN(10'(MINB)), .MAXBIN(10'(MAXB)), .THRESH(TH)) dut (
      .clk(clk), .reset(reset), .fftdone(fftdone), .ram1q(ram1q), .wbdone(wbdone),
      .rdaddr1(rdaddr1), .maxbin(maxbin), .maxpwr(maxpwr),
      .detectdone(detectdone), .nosig(nosig), .busy(busy)
   );

   always #5 clk = ~clk;

   // Read data for the registered address is available within the same cycle
   assign ram1q = mem[rdaddr1];

   int vec = 0;
   int bad = 0;

   // Reference model state: 0 idle, 1 scanning/draining, 2 holding
   int          st = 0;
   int          d = 0;
   logic [9:0]  e_rd = '0;
   logic [9:0]  e_mb = '0;
   logic [27:0] e_mp = '0;
   logic        e_dd = 1'b0;
   logic        e_ns = 1'b0;
   logic        e_bs = 1'b0;
   logic [27:0] pre_p [0:NB];
   logic [9:0]  pre_b [0:NB];

   function automatic logic [27:0] pk(input int re, input int im);
      logic [27:0] r;
      r = {re[13:0], im[13:0]};
      return r;
   endfunction

   function automatic logic [27:0] pw(input logic [27:0] q);
      int re;
      int im;
      re = int'($signed(q[27:14]));
      im = int'($signed(q[13:0]));
      return 28'(re * re + im * im);
   endfunction

   // pre_p[j]/pre_b[j]: running maximum after the first j scanned bins, lowest bin wins ties
   task automatic build_prefix();
      logic [27:0] p;
      pre_p[0] = '0;
      pre_b[0] = '0;
      for (int j = 1; j <= NB; j++) begin
         p = pw(mem[MINB + j - 1]);
         if (p > pre_p[j-1]) begin
            pre_p[j] = p;
            pre_b[j] = 10'(MINB + j - 1);
         end else begin
            pre_p[j] = pre_p[j-1];
            pre_b[j] = pre_b[j-1];
         end
      end
   endtask

   task automatic model_reset();
      st = 0; d = 0;
      e_rd = '0; e_mb = '0; e_mp = '0;
      e_dd = 1'b0; e_ns = 1'b0; e_bs = 1'b0;
   endtask

   task automatic model_edge(input logic f, input logic w);
      int cnt;
      e_ns = 1'b0;
      if (!reset) begin
         model_reset();
      end else if (st == 0) begin
         if (f) begin
            build_prefix();
            st = 1; d = 0;
            e_bs = 1'b1; e_rd = 10'(MINB); e_mp = '0; e_mb = '0;
         end
      end else if (st == 1) begin
         d++;
         if (d == NB + 3) begin
            e_bs = 1'b0;
            e_mp = pre_p[NB];
            e_mb = pre_b[NB];
            if (pre_p[NB] >= TH) begin
               st = 2; e_dd = 1'b1; e_rd = pre_b[NB];
            end else begin
               st = 0; e_ns = 1'b1; e_rd = '0;
            end
         end else begin
            e_rd = (d < NB) ? 10'(MINB + d) : 10'(MAXB);
            cnt = d - 1;
            if (cnt < 0) cnt = 0;
            if (cnt > NB) cnt = NB;
            e_mp = pre_p[cnt];
            e_mb = pre_b[cnt];
         end
      end else begin
         if (w) begin
            st = 0; e_dd = 1'b0; e_rd = '0;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("rdaddr1", 32'(rdaddr1), 32'(e_rd));
      chk("maxbin", 32'(maxbin), 32'(e_mb));
      chk("maxpwr", 32'(maxpwr), 32'(e_mp));
      chk("detectdone", 32'(detectdone), 32'(e_dd));
      chk("nosig", 32'(nosig), 32'(e_ns));
      chk("busy", 32'(busy), 32'(e_bs));
   endtask

   task automatic step(input logic f, input logic w);
      fftdone = f;
      wbdone  = w;
      @(posedge clk);
      model_edge(f, w);
      @(negedge clk);
      compare();
      fftdone = 1'b0;
      wbdone  = 1'b0;
   endtask

   task automatic scan(input int ign, output int lat);
      step(1'b1, 1'b0);
      lat = 0;
      for (int i = 1; i < 600; i++) begin
         step(i == ign, $urandom_range(0, 63) == 0);
         if (detectdone || nosig) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic release_hold(input int dly);
      repeat (dly) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      chk("release", 32'(detectdone), 32'd0);
      step(1'b0, 1'b0);
   endtask

   task automatic fill(input int re, input int im);
      for (int b = 0; b < 1024; b++) mem[b] = pk(re, im);
   endtask

   task automatic fill_random(input int mode);
      int a;
      for (int b = 0; b < 1024; b++) begin
         case (mode)
            0: begin
               a = $urandom_range(0, 80);
               mem[b] = pk(a - 40, int'($urandom_range(0, 80)) - 40);
            end
            1: mem[b] = 28'($urandom);
            2: mem[b] = pk(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
            default: mem[b] = '0;
         endcase
      end
      if (mode == 2) begin
         mem[0] = pk(8191, 8191);
         mem[$urandom_range(MINB, MAXB)] = pk(int'($urandom_range(0, 16383)) - 8192, 777);
      end
   endtask

   int lat;

   initial begin
      fill(0, 0);
      model_reset();
      repeat (3) step(1'b0, 1'b0);
      reset = 1'b1;
      repeat (2) step(1'b0, 1'b0);

      // Single tone with extra fftdone pulses during scan and hold
      fill(10, 10);
      mem[37] = pk(1000, -500);
      scan(100, lat);
      chk("tone_latency", 32'(lat), 32'd514);
      chk("tone_maxbin", 32'(maxbin), 32'd37);
      chk("tone_maxpwr", 32'(maxpwr), 32'd1250000);
      chk("tone_rdaddr1", 32'(rdaddr1), 32'd37);
      chk("tone_detect", 32'(detectdone), 32'd1);
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      chk("hold_ignores_fft", 32'(maxbin), 32'd37);
      release_hold(2);

      // Tie keeps the lowest bin
      fill(0, 0);
      mem[100] = pk(300, 400);
      mem[200] = pk(300, 400);
      scan(0, lat);
      chk("tie_maxbin", 32'(maxbin), 32'd100);
      chk("tie_maxpwr", 32'(maxpwr), 32'd250000);
      release_hold(0);

      // Below threshold
      fill(5, 5);
      scan(0, lat);
      chk("low_latency", 32'(lat), 32'd514);
      chk("low_nosig", 32'(nosig), 32'd1);
      chk("low_busy", 32'(busy), 32'd0);
      chk("low_detect", 32'(detectdone), 32'd0);
      step(1'b0, 1'b0);
      chk("low_nosig_pulse", 32'(nosig), 32'd0);
      step(1'b0, 1'b0);

      // Extremes, peak in the last scanned bin
      fill(8191, 0);
      mem[511] = pk(-8192, -8192);
      scan(0, lat);
      chk("ext_maxbin", 32'(maxbin), 32'd511);
      chk("ext_maxpwr", 32'(maxpwr), 32'd134217728);
      release_hold(1);

      // Reset in the middle of a scan
      fill_random(1);
      step(1'b1, 1'b0);
      repeat (199) step(1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("rst_rdaddr1", 32'(rdaddr1), 32'd0);
      chk("rst_maxpwr", 32'(maxpwr), 32'd0);
      chk("rst_maxbin", 32'(maxbin), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_detect", 32'(detectdone), 32'd0);
      model_reset();
      repeat (3) step(1'b0, 1'b0);
      reset = 1'b1;
      step(1'b0, 1'b0);
      scan(0, lat);
      chk("post_rst_latency", 32'(lat), 32'd514);
      if (detectdone) release_hold(0);
      else step(1'b0, 1'b0);

      // Randomized frames
      for (int n = 0; n < 8; n++) begin
         fill_random(int'($urandom_range(0, 3)));
         scan(int'($urandom_range(1, 520)), lat);
         if (detectdone) release_hold(int'($urandom_range(0, 5)));
         else repeat (int'($urandom_range(0, 3))) step(1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
